// File: rtl/pipe_ctrl.sv
// Frame-level controller for an HLS filter: waits for vsync, starts the filter, tracks
// completion, aborts on timeout with a capture-off flush, and registers the filter's coordinate.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FLUSH_CYCLES   = 16,
    parameter int unsigned FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              init_done,
    input  logic              vsync,
    input  logic [2:0]        sel_req,
    input  logic              sel_req_valid,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic [9:0]        coord_V,
    input  logic              coord_V_ap_vld,
    output logic              ap_start,
    output logic [2:0]        sel_V,
    output logic              capture_en,
    output logic [9:0]        coord_out,
    output logic              coord_valid,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              timeout_err,
    output logic              busy
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_VS = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_FLUSH   = 3'd4;

    logic [2:0]        r_state;
    logic              r_vs_prev;
    logic [2:0]        r_sel_pend;
    logic [2:0]        r_sel_v;
    logic              r_ap_start;
    logic              r_capture_en;
    logic [9:0]        r_coord_out;
    logic              r_coord_valid;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_timeout_err;
    logic              r_busy;
    logic [TO_W-1:0]   r_to_cnt;
    logic [FL_W-1:0]   r_fl_cnt;

    logic [2:0] w_state_nxt;
    logic       w_vs_rise;
    logic       w_to_hit;
    logic       w_fl_hit;
    logic       w_enter_start;
    logic       w_frame_done;
    logic       w_abort;
    logic       w_flush_end;
    logic       w_coord_load;

    assign w_vs_rise    = vsync & ~r_vs_prev;
    assign w_to_hit     = (r_to_cnt == TO_LAST);
    assign w_fl_hit     = (r_fl_cnt == FL_LAST);
    assign w_coord_load = coord_V_ap_vld & (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_start = 1'b0;
        w_frame_done  = 1'b0;
        w_abort       = 1'b0;
        w_flush_end   = 1'b0;
        if (!init_done) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    // A vsync edge seen while the filter is not idle is simply lost.
                    if (w_vs_rise && ap_idle) begin
                        w_state_nxt   = ST_START;
                        w_enter_start = 1'b1;
                    end
                end
                ST_START: begin
                    if (ap_ready && ap_done) begin
                        w_state_nxt  = ST_WAIT_VS;
                        w_frame_done = 1'b1;
                    end else if (w_to_hit) begin
                        w_state_nxt = ST_FLUSH;
                        w_abort     = 1'b1;
                    end else if (ap_ready) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ap_done) begin
                        w_state_nxt  = ST_WAIT_VS;
                        w_frame_done = 1'b1;
                    end else if (w_to_hit) begin
                        w_state_nxt = ST_FLUSH;
                        w_abort     = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (w_fl_hit) begin
                        w_state_nxt = ST_WAIT_VS;
                        w_flush_end = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_vs_prev <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vs_prev <= vsync;
            r_busy    <= (w_state_nxt == ST_START) || (w_state_nxt == ST_RUN) ||
                         (w_state_nxt == ST_FLUSH);
        end
    end

    // Pending select is captured anywhere; it reaches the filter only on START entry.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_sel_pend <= 3'd0;
            r_sel_v    <= 3'd0;
        end else begin
            if (sel_req_valid) begin
                r_sel_pend <= sel_req;
            end
            if (w_enter_start) begin
                r_sel_v <= r_sel_pend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_ap_start   <= 1'b0;
            r_capture_en <= 1'b0;
        end else begin
            r_ap_start <= (w_state_nxt == ST_START);
            if (w_state_nxt == ST_IDLE) begin
                r_capture_en <= 1'b0;
            end else if (w_enter_start || w_flush_end) begin
                r_capture_en <= 1'b1;
            end else if (w_abort) begin
                r_capture_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_to_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_enter_start) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_START) || (r_state == ST_RUN)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_abort) begin
                r_fl_cnt <= '0;
            end else if (r_state == ST_FLUSH) begin
                r_fl_cnt <= r_fl_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_coord_out   <= 10'd0;
            r_coord_valid <= 1'b0;
        end else begin
            r_coord_valid <= w_coord_load;
            if (w_coord_load) begin
                r_coord_out <= coord_V;
            end
        end
    end

    assign ap_start    = r_ap_start;
    assign sel_V       = r_sel_v;
    assign capture_en  = r_capture_en;
    assign coord_out   = r_coord_out;
    assign coord_valid = r_coord_valid;
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule
